// File: rtl/aes_pkg.sv
// Shared types and round-constant helpers for the AES-128 decrypt-side key schedule.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam logic [7:0] RCON_LAST  = 8'h36;
    localparam logic [7:0] RCON_WRAP  = 8'h1B;
    localparam logic [7:0] RCON_TOP   = 8'h80;
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Walks the round-constant sequence backwards: 36,1B,80,40,...,01.
    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        return (r == RCON_WRAP) ? RCON_TOP : (r >> 1);
    endfunction

endpackage

// File: rtl/g_function.sv
// AES key-expansion g(): RotWord, SubWord, then round constant into the MSB byte.
module g_function
    import aes_pkg::*;
(
    input  logic [31:0] input_word,
    input  logic [7:0]  current_round_constant,
    output logic [31:0] gee
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, with 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w_rot;

    assign w_rot = {input_word[23:0], input_word[31:24]};
    assign gee   = {sbox(w_rot[31:24]) ^ current_round_constant,
                    sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]),
                    sbox(w_rot[7:0])};

endmodule

// File: rtl/inv_key_scheduler.sv
// Decrypt-side AES-128 key schedule: issues round keys 10..0, deriving each previous key from the current one.
module inv_key_scheduler
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
    output logic         sched_done,
    output sched_state_t dbg_state
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_num;
    logic [7:0]   r_rcon;
    logic         r_key_valid;
    logic         r_busy;
    logic         r_sched_done;

    logic         w_hs;
    logic         w_load;
    logic         w_step;
    logic         w_valid_nxt;
    logic         w_busy_nxt;
    logic         w_done_nxt;
    logic [31:0]  w_p0;
    logic [31:0]  w_p1;
    logic [31:0]  w_p2;
    logic [31:0]  w_p3;
    logic [31:0]  w_gee;

    assign w_hs = r_key_valid & key_ready;

    // Inverse of w[i] = w[i-4] ^ w[i-1]; only the first word needs g().
    assign w_p3 = r_round_key[31:0]   ^ r_round_key[63:32];
    assign w_p2 = r_round_key[63:32]  ^ r_round_key[95:64];
    assign w_p1 = r_round_key[95:64]  ^ r_round_key[127:96];
    assign w_p0 = r_round_key[127:96] ^ w_gee;

    g_function u_g_function (
        .input_word             (w_p3),
        .current_round_constant (r_rcon),
        .gee                    (w_gee)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start && !abort) w_state_nxt = RUN;
            RUN: begin
                if (abort)                                   w_state_nxt = IDLE;
                else if (w_hs && (r_round_num == 4'd0))      w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load      = (r_state == IDLE) && start && !abort;
        w_step      = (r_state == RUN) && !abort && w_hs && (r_round_num != 4'd0);
        w_valid_nxt = (w_state_nxt == RUN);
        w_busy_nxt  = (w_state_nxt == RUN);
        w_done_nxt  = (r_state == RUN) && (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_round_key  <= '0;
            r_round_num  <= '0;
            r_rcon       <= RCON_LAST;
            r_key_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_sched_done <= 1'b0;
        end else begin
            r_key_valid  <= w_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_sched_done <= w_done_nxt;
            if (w_load) begin
                r_round_key <= last_key;
                r_round_num <= NUM_ROUNDS;
                r_rcon      <= RCON_LAST;
            end else if (w_step) begin
                r_round_key <= {w_p0, w_p1, w_p2, w_p3};
                r_round_num <= r_round_num - 4'd1;
                r_rcon      <= inv_xtime(r_rcon);
            end
        end
    end

    assign round_key  = r_round_key;
    assign round_num  = r_round_num;
    assign key_valid  = r_key_valid;
    assign busy       = r_busy;
    assign sched_done = r_sched_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Bench for inv_key_scheduler: forward FIPS-197 key expansion model feeds an expected queue of decrypt-order keys.
module tb_inv_key_scheduler;
    import aes_pkg::*;

    localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A1_R9   = 128'hac7766f319fadc2128d12941575c006e;

    logic         clk;
    logic         clk_en;
    logic         n_rst;
    logic         start;
    logic         abort;
    logic [127:0] last_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         sched_done;
    sched_state_t dbg_state;

    inv_key_scheduler dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .abort      (abort),
        .last_key   (last_key),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .round_num  (round_num),
        .key_valid  (key_valid),
        .busy       (busy),
        .sched_done (sched_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    int vectors;
    int miscompares;

    // reference model and scoreboard
    logic [2047:0] sbox_tab;
    logic [127:0]  exp_rk [0:10];
    logic [127:0]  exp_q [$];

    logic [127:0]  obs_key_q [$];
    logic [3:0]    obs_num_q [$];
    int            done_cnt;
    int            done_cyc;
    int            n_valid;
    int            stall_viol;
    int            valid_after_done;
    bit            timed_out;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tab[(255 - int'(x)) * 8 +: 8];
    endfunction

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
        exp_q.delete();
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        for (int r = 10; r >= 0; r--) exp_q.push_back(exp_rk[r]);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // driver: one schedule, recording every accepted key
    task automatic run_sched(input logic [127:0] lk, input bit bp, input bit inj);
        logic [127:0] stall_key;
        bit           stall_pend;
        bit           rdy;
        int           cyc;
        int           post;
        obs_key_q.delete();
        obs_num_q.delete();
        done_cnt = 0; done_cyc = -1; n_valid = 0; stall_viol = 0; valid_after_done = 0;
        stall_pend = 0; stall_key = '0; cyc = 0; post = 0;
        @(negedge clk);
        abort = 0; start = 1; last_key = lk; key_ready = 1;
        while (cyc < 300 && !(done_cnt > 0 && post >= 2)) begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (done_cnt > 0) post++;
            if (sched_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (key_valid) begin
                if (inj && $urandom_range(0, 3) == 0) begin
                    start = 1;
                    last_key = rand128();
                end
                if (done_cnt > 0) valid_after_done++;
                n_valid++;
                if (stall_pend && round_key !== stall_key) stall_viol++;
                rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                key_ready = rdy;
                if (rdy) begin
                    obs_key_q.push_back(round_key);
                    obs_num_q.push_back(round_num);
                    stall_pend = 0;
                end else begin
                    stall_pend = 1;
                    stall_key = round_key;
                end
            end else begin
                stall_pend = 0;
                key_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        timed_out = (done_cnt == 0);
        start = 0;
        key_ready = 0;
    endtask

    task automatic test_reset();
        n_rst = 0;
        repeat (2) @(negedge clk);
        vectors++; if (round_key !== 128'h0) begin miscompares++; $display("FAIL rst_round_key: got %h expected 0", round_key); end
        vectors++; if (round_num !== 4'd0) begin miscompares++; $display("FAIL rst_round_num: got %0d expected 0", round_num); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_key_valid: got %b expected 0", key_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (sched_done !== 1'b0) begin miscompares++; $display("FAIL rst_sched_done: got %b expected 0", sched_done); end
        n_rst = 1;
        repeat (2) @(negedge clk);
        vectors++; if (dbg_state !== IDLE || key_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_idle: got state %0d valid %b expected IDLE/0", dbg_state, key_valid);
        end
    endtask

    task automatic test_fips_a1();
        expand_key(A1_KEY);
        run_sched(A1_LAST, 0, 0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL a1_timeout: got no sched_done expected pulse"); end
        vectors++; if (obs_key_q.size() != 11) begin miscompares++; $display("FAIL a1_count: got %0d expected 11", obs_key_q.size()); end
        vectors++; if (n_valid != 11) begin miscompares++; $display("FAIL a1_valid_cycles: got %0d expected 11", n_valid); end
        vectors++; if (done_cyc != 12) begin miscompares++; $display("FAIL a1_done_cycle: got %0d expected 12", done_cyc); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL a1_done_width: got %0d expected 1", done_cnt); end
        vectors++; if (valid_after_done != 0) begin miscompares++; $display("FAIL a1_valid_after_done: got %0d expected 0", valid_after_done); end
        for (int i = 0; i < obs_key_q.size() && i < 11; i++) begin
            vectors++; if (obs_key_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL a1_key[%0d]: got %h expected %h", i, obs_key_q[i], exp_q[i]); end
            vectors++; if (obs_num_q[i] !== 4'(10 - i)) begin miscompares++; $display("FAIL a1_num[%0d]: got %0d expected %0d", i, obs_num_q[i], 10 - i); end
        end
        if (obs_key_q.size() == 11) begin
            vectors++; if (obs_key_q[0] !== A1_LAST) begin miscompares++; $display("FAIL a1_round10: got %h expected %h", obs_key_q[0], A1_LAST); end
            vectors++; if (obs_key_q[1] !== A1_R9) begin miscompares++; $display("FAIL a1_round9: got %h expected %h", obs_key_q[1], A1_R9); end
            vectors++; if (obs_key_q[10] !== A1_KEY) begin miscompares++; $display("FAIL a1_round0: got %h expected %h", obs_key_q[10], A1_KEY); end
        end
        vectors++; if (busy !== 1'b0 || dbg_state !== IDLE) begin miscompares++; $display("FAIL a1_end_idle: got busy %b state %0d expected 0/IDLE", busy, dbg_state); end
    endtask

    task automatic test_backpressure();
        logic [127:0] orig;
        for (int run = 0; run < 3; run++) begin
            orig = (run == 0) ? A1_KEY : rand128();
            expand_key(orig);
            run_sched(exp_rk[10], 1, 0);
            vectors++; if (timed_out || obs_key_q.size() != 11) begin
                miscompares++; $display("FAIL bp_count[%0d]: got %0d keys timeout %b expected 11/0", run, obs_key_q.size(), timed_out);
            end
            vectors++; if (stall_viol != 0) begin miscompares++; $display("FAIL bp_stable[%0d]: got %0d changes expected 0", run, stall_viol); end
            vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL bp_done[%0d]: got %0d expected 1", run, done_cnt); end
            for (int i = 0; i < obs_key_q.size() && i < 11; i++) begin
                vectors++; if (obs_key_q[i] !== exp_q[i] || obs_num_q[i] !== 4'(10 - i)) begin
                    miscompares++; $display("FAIL bp_key[%0d][%0d]: got %h/%0d expected %h/%0d", run, i, obs_key_q[i], obs_num_q[i], exp_q[i], 10 - i);
                end
            end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        for (int run = 0; run < 20; run++) begin
            orig = rand128();
            expand_key(orig);
            run_sched(exp_rk[10], run[0], 0);
            vectors++; if (obs_key_q.size() != 11) begin miscompares++; $display("FAIL rt_count[%0d]: got %0d expected 11", run, obs_key_q.size()); end
            if (obs_key_q.size() == 11) begin
                vectors++; if (obs_key_q[10] !== orig) begin miscompares++; $display("FAIL rt_final[%0d]: got %h expected %h", run, obs_key_q[10], orig); end
                vectors++; if (obs_key_q[5] !== exp_rk[5]) begin miscompares++; $display("FAIL rt_round5[%0d]: got %h expected %h", run, obs_key_q[5], exp_rk[5]); end
            end
        end
    endtask

    task automatic test_abort();
        int  cyc;
        int  pulses;
        bit  hit;
        expand_key(A1_KEY);
        @(negedge clk);
        start = 1; abort = 1; last_key = A1_LAST; key_ready = 1;
        @(negedge clk);
        start = 0; abort = 0;
        vectors++; if (key_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++; $display("FAIL start_abort_idle: got valid %b busy %b state %0d expected 0/0/IDLE", key_valid, busy, dbg_state);
        end
        start = 1;
        cyc = 0; hit = 0;
        while (cyc < 20 && !hit) begin
            @(negedge clk);
            start = 0;
            cyc++;
            if (key_valid && round_num == 4'd5) hit = 1;
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL abort_reach5: got no round 5 within %0d cycles expected round 5", cyc); end
        key_ready = 0; abort = 1;
        @(negedge clk);
        abort = 0;
        vectors++; if (key_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_drop: got valid %b busy %b expected 0/0", key_valid, busy); end
        vectors++; if (round_num !== 4'd5 || round_key !== exp_rk[5]) begin
            miscompares++; $display("FAIL abort_hold: got %0d/%h expected 5/%h", round_num, round_key, exp_rk[5]);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (sched_done) pulses++;
            @(negedge clk);
        end
        vectors++; if (pulses != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        run_sched(A1_LAST, 0, 0);
        vectors++; if (obs_key_q.size() != 11) begin miscompares++; $display("FAIL abort_restart_count: got %0d expected 11", obs_key_q.size()); end
        if (obs_key_q.size() == 11) begin
            vectors++; if (obs_key_q[0] !== A1_LAST || obs_num_q[0] !== 4'd10) begin
                miscompares++; $display("FAIL abort_restart_r10: got %h/%0d expected %h/10", obs_key_q[0], obs_num_q[0], A1_LAST);
            end
            vectors++; if (obs_key_q[10] !== A1_KEY) begin miscompares++; $display("FAIL abort_restart_r0: got %h expected %h", obs_key_q[10], A1_KEY); end
        end
    endtask

    task automatic test_start_during_run();
        logic [127:0] orig;
        for (int run = 0; run < 3; run++) begin
            orig = rand128();
            expand_key(orig);
            run_sched(exp_rk[10], run[0], 1);
            vectors++; if (obs_key_q.size() != 11 || done_cnt != 1) begin
                miscompares++; $display("FAIL sdr_count[%0d]: got %0d keys %0d pulses expected 11/1", run, obs_key_q.size(), done_cnt);
            end
            for (int i = 0; i < obs_key_q.size() && i < 11; i++) begin
                vectors++; if (obs_key_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL sdr_key[%0d][%0d]: got %h expected %h", run, i, obs_key_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_async_reset();
        expand_key(A1_KEY);
        @(negedge clk);
        start = 1; last_key = A1_LAST; key_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        clk_en = 0;
        #3;
        n_rst = 0;
        #1;
        vectors++; if (round_key !== 128'h0 || round_num !== 4'd0) begin
            miscompares++; $display("FAIL arst_key: got %h/%0d expected 0/0", round_key, round_num);
        end
        vectors++; if (key_valid !== 1'b0 || busy !== 1'b0 || sched_done !== 1'b0 || dbg_state !== IDLE) begin
            miscompares++; $display("FAIL arst_ctrl: got valid %b busy %b done %b state %0d expected 0/0/0/IDLE", key_valid, busy, sched_done, dbg_state);
        end
        #3;
        n_rst = 1;
        #1;
        clk_en = 1;
        run_sched(A1_LAST, 0, 0);
        vectors++; if (obs_key_q.size() != 11 || done_cnt != 1) begin
            miscompares++; $display("FAIL arst_rerun_count: got %0d keys %0d pulses expected 11/1", obs_key_q.size(), done_cnt);
        end
        for (int i = 0; i < obs_key_q.size() && i < 11; i++) begin
            vectors++; if (obs_key_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL arst_key[%0d]: got %h expected %h", i, obs_key_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clk_en = 1;
        n_rst = 0;
        start = 0;
        abort = 0;
        last_key = '0;
        key_ready = 0;
        sbox_tab = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        test_reset();
        test_fips_a1();
        test_backpressure();
        test_round_trip();
        test_abort();
        test_start_during_run();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
